// File: rtl/crypto_cmd_sequencer.sv
// rtl/crypto_cmd_sequencer.sv - host command sequencer for coprocessor register file and key slices
//
// Decodes 32-bit host commands (instr[31:30]: 00 READ, 01 WRITE, 10 KEYLOAD, 11 NOP,
// instr[3:0] = register select). READ streams the selected register out one 32-bit word
// per cycle, WRITE gathers payload words into write_bus and commits with a one-cycle
// write_enable strobe, KEYLOAD holds key_we while slice_sel steps through the key slices.
// Per-register lengths come from LEN_TABLE / KEY_TABLE; illegal selects or zero lengths
// pulse err and leave the sequencer idle.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   instr, instr_valid/ready command and payload word handshake
//   rd_data, rd_sel          register-file read data and its select
//   out_data, out_valid      streamed read words
//   write_bus, write_enable  gathered write payload and one-hot commit strobe
//   key_we, slice_sel        one-hot key write enable and current slice index
//   busy, err                not-idle flag and illegal-command pulse
//   abort                    present only when CMD_ABORT_EN is defined
//
// Optional feature macro: CMD_ABORT_EN
module crypto_cmd_sequencer #(
    parameter int DATA_W   = 448,
    parameter int NREG     = 16,
    parameter int NKEY     = 6,
    parameter int NSLICE_W = 5,
    parameter logic [8*NREG-1:0] LEN_TABLE = {8'd0, 8'd3, 8'd7, 8'd9, 8'd11, 8'd13, 8'd2, 8'd5,
                                              8'd6, 8'd10, 8'd20, 8'd14, 8'd8, 8'd4, 8'd2, 8'd1},
    parameter logic [8*NKEY-1:0] KEY_TABLE = {8'd1, 8'd0, 8'd32, 8'd3, 8'd2, 8'd5}
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [3:0]          rd_sel,
    output logic [31:0]         out_data,
    output logic                out_valid,
    output logic [DATA_W-1:0]   write_bus,
    output logic [NREG-1:0]     write_enable,
    output logic [NKEY-1:0]     key_we,
    output logic [NSLICE_W-1:0] slice_sel,
    output logic                busy,
    output logic                err
`ifdef CMD_ABORT_EN
    ,
    input  logic                abort
`endif
);

    localparam int WORDS = DATA_W / 32;

    // Largest count any legal sequence can reach, after READ/WRITE lengths are clamped.
    function automatic int table_max();
        int m;
        int e;
        m = 0;
        for (int i = 0; i < NREG; i++) begin
            e = int'(LEN_TABLE[8*i +: 8]);
            if (e > WORDS) e = WORDS;
            if (e > m) m = e;
        end
        for (int i = 0; i < NKEY; i++) begin
            e = int'(KEY_TABLE[8*i +: 8]);
            if (e > m) m = e;
        end
        return m;
    endfunction

    localparam int MAXE  = table_max();
    localparam int CNT_W = (MAXE < 1) ? 1 : $clog2(MAXE + 1);

    // Tables padded to 16 entries so any 4-bit select indexes in range; pad entries read as 0.
    localparam logic [127:0] LEN_PAD = 128'(LEN_TABLE);
    localparam logic [127:0] KEY_PAD = 128'(KEY_TABLE);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_COMMIT, S_KEY} state_t;

    state_t           state;
    logic [3:0]       sel_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       cmd_op;
    logic [3:0]       cmd_sel;
    logic [7:0]       len_raw;
    logic [7:0]       key_raw;
    logic [CNT_W-1:0] rw_len;
    logic [CNT_W-1:0] key_len;
    logic             rw_ok;
    logic             key_ok;
    logic             last;

    assign cmd_op  = instr[31:30];
    assign cmd_sel = instr[3:0];

    always_comb begin
        len_raw = LEN_PAD[{cmd_sel, 3'b000} +: 8];
        key_raw = KEY_PAD[{cmd_sel, 3'b000} +: 8];
        rw_len  = (int'(len_raw) > WORDS) ? CNT_W'(WORDS) : CNT_W'(len_raw);
        key_len = CNT_W'(key_raw);
        rw_ok   = (int'(cmd_sel) < NREG) && (len_raw != 8'd0);
        key_ok  = (int'(cmd_sel) < NKEY) && (key_raw != 8'd0);
    end

    assign last     = (cnt == len_q - CNT_W'(1));
    assign busy     = (state != S_IDLE);
    // rd_data follows rd_sel combinationally, so the word mux sits after the register file.
    assign out_data = out_valid ? rd_data[32*int'(cnt) +: 32] : 32'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            len_q        <= '0;
            cnt          <= '0;
            instr_ready  <= 1'b1;
            rd_sel       <= '0;
            out_valid    <= 1'b0;
            write_bus    <= '0;
            write_enable <= '0;
            key_we       <= '0;
            slice_sel    <= '0;
            err          <= 1'b0;
        end else begin
            err          <= 1'b0;
            write_enable <= '0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        cnt <= '0;
                        case (cmd_op)
                            2'b00: begin
                                if (rw_ok) begin
                                    state       <= S_READ;
                                    rd_sel      <= cmd_sel;
                                    sel_q       <= cmd_sel;
                                    len_q       <= rw_len;
                                    out_valid   <= 1'b1;
                                    instr_ready <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            2'b01: begin
                                if (rw_ok) begin
                                    state     <= S_WRITE;
                                    rd_sel    <= cmd_sel;
                                    sel_q     <= cmd_sel;
                                    len_q     <= rw_len;
                                    write_bus <= '0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            2'b10: begin
                                if (key_ok) begin
                                    state       <= S_KEY;
                                    rd_sel      <= cmd_sel;
                                    sel_q       <= cmd_sel;
                                    len_q       <= key_len;
                                    key_we      <= {{(NKEY-1){1'b0}}, 1'b1} << cmd_sel;
                                    slice_sel   <= '0;
                                    instr_ready <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_READ: begin
                    if (last) begin
                        state       <= S_IDLE;
                        out_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (instr_valid) begin
                        write_bus[32*int'(cnt) +: 32] <= instr;
                        if (last) begin
                            state        <= S_COMMIT;
                            instr_ready  <= 1'b0;
                            write_enable <= {{(NREG-1){1'b0}}, 1'b1} << sel_q;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
                S_KEY: begin
                    if (last) begin
                        state       <= S_IDLE;
                        key_we      <= '0;
                        slice_sel   <= '0;
                        instr_ready <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        slice_sel <= NSLICE_W'(cnt + CNT_W'(1));
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef CMD_ABORT_EN
            // Abort overrides whatever the active sequence scheduled this cycle.
            if (abort && (state == S_READ || state == S_WRITE || state == S_KEY)) begin
                state        <= S_IDLE;
                out_valid    <= 1'b0;
                write_bus    <= '0;
                write_enable <= '0;
                key_we       <= '0;
                slice_sel    <= '0;
                instr_ready  <= 1'b1;
                cnt          <= '0;
                err          <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_crypto_cmd_sequencer.sv
// tb/tb_crypto_cmd_sequencer.sv - self-checking bench for crypto_cmd_sequencer
module tb_crypto_cmd_sequencer;

    localparam int DATA_W = 448;
    localparam int WORDS  = 14;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       instr = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        rd_sel;
    logic [31:0]       out_data;
    logic              out_valid;
    logic [DATA_W-1:0] write_bus;
    logic [15:0]       write_enable;
    logic [5:0]        key_we;
    logic [4:0]        slice_sel;
    logic              busy;
    logic              err;
`ifdef CMD_ABORT_EN
    logic              abort = 1'b0;
`endif

    logic [DATA_W-1:0] regfile [16];
    assign rd_data = regfile[rd_sel];

    int len_tab [16] = '{1, 2, 4, 8, 14, 20, 10, 6, 5, 2, 13, 11, 9, 7, 3, 0};
    int key_tab [6]  = '{5, 2, 3, 32, 0, 1};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    crypto_cmd_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .rd_data      (rd_data),
        .rd_sel       (rd_sel),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .write_bus    (write_bus),
        .write_enable (write_enable),
        .key_we       (key_we),
        .slice_sel    (slice_sel),
        .busy         (busy),
        .err          (err)
`ifdef CMD_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    function automatic int rw_len(input int sel);
        if (sel > 15) return 0;
        return (len_tab[sel] > WORDS) ? WORDS : len_tab[sel];
    endfunction

    function automatic int key_len(input int sel);
        return (sel < 6) ? key_tab[sel] : 0;
    endfunction

    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] sel);
        instr       = {op, 26'd0, sel};
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int r = 0; r < 16; r++)
            for (int w = 0; w < WORDS; w++)
                regfile[r][32*w +: 32] = $urandom;
        repeat (2) @(negedge clock);
        n_checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags ready=%b busy=%b err=%b out_valid=%b expected 1 0 0 0",
                     instr_ready, busy, err, out_valid);
        end
        n_checks++;
        if (write_bus !== '0 || write_enable !== '0 || key_we !== '0 || slice_sel !== '0 ||
            rd_sel !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_buses we=%h key_we=%h slice=%0d rd_sel=%0d out=%h expected all 0",
                     write_enable, key_we, slice_sel, rd_sel, out_data);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_read(input int sel, input bit ramp);
        int len;
        logic [31:0] exp_w;
        len = rw_len(sel);
        for (int w = 0; w < WORDS; w++)
            regfile[sel][32*w +: 32] = ramp ? 32'(w + 1) : $urandom;
        drive_cmd(2'b00, 4'(sel));
        for (int k = 0; k < len; k++) begin
            exp_w = regfile[sel][32*k +: 32];
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w || instr_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL read_word sel=%0d k=%0d valid=%b data=%h ready=%b expected 1 %h 0",
                         sel, k, out_valid, out_data, instr_ready, exp_w);
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_end sel=%0d valid=%b busy=%b ready=%b expected 0 0 1",
                     sel, out_valid, busy, instr_ready);
        end
    endtask

    task automatic test_write(input int sel, input bit force_gap);
        int len;
        logic [DATA_W-1:0] exp_bus;
        logic [15:0] exp_we;
        logic [31:0] word;
        len     = rw_len(sel);
        exp_bus = '0;
        exp_we  = '0;
        exp_we[sel] = 1'b1;
        drive_cmd(2'b01, 4'(sel));
        for (int k = 0; k < len; k++) begin
            if ((force_gap && k == 1) || $urandom_range(0, 3) == 0) begin
                @(negedge clock);
                n_checks++;
                if (write_enable !== '0 || busy !== 1'b1 || instr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_gap sel=%0d k=%0d we=%h busy=%b ready=%b expected 0 1 1",
                             sel, k, write_enable, busy, instr_ready);
                end
            end
            word = $urandom;
            exp_bus[32*k +: 32] = word;
            instr = word;
            instr_valid = 1'b1;
            @(negedge clock);
            instr_valid = 1'b0;
            instr = '0;
            if (k < len - 1) begin
                n_checks++;
                if (write_enable !== '0 || instr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_early sel=%0d k=%0d we=%h ready=%b expected 0 1",
                             sel, k, write_enable, instr_ready);
                end
            end
        end
        n_checks++;
        if (write_enable !== exp_we || write_bus !== exp_bus || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_commit sel=%0d we=%h ready=%b bus=%h expected we=%h ready=0 bus=%h",
                     sel, write_enable, instr_ready, write_bus[127:0], exp_we, exp_bus[127:0]);
        end
        @(negedge clock);
        n_checks++;
        if (write_enable !== '0 || write_bus !== exp_bus || busy !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_after sel=%0d we=%h busy=%b ready=%b bus_ok=%b expected 0 0 1 1",
                     sel, write_enable, busy, instr_ready, write_bus === exp_bus);
        end
    endtask

    task automatic test_key(input int sel);
        int n;
        logic [5:0] exp_kwe;
        n = key_len(sel);
        exp_kwe = '0;
        exp_kwe[sel] = 1'b1;
        drive_cmd(2'b10, 4'(sel));
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (key_we !== exp_kwe || slice_sel !== 5'(i) || busy !== 1'b1 || instr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL key_step sel=%0d i=%0d key_we=%b slice=%0d busy=%b expected %b %0d 1",
                         sel, i, key_we, slice_sel, busy, exp_kwe, i);
            end
            @(negedge clock);
        end
        n_checks++;
        if (key_we !== '0 || slice_sel !== '0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL key_end sel=%0d key_we=%b slice=%0d busy=%b ready=%b expected 0 0 0 1",
                     sel, key_we, slice_sel, busy, instr_ready);
        end
    endtask

    task automatic test_error(input logic [1:0] op, input int sel);
        drive_cmd(op, 4'(sel));
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || key_we !== '0 || write_enable !== '0) begin
            n_fail++;
            $display("FAIL err_pulse op=%0d sel=%0d err=%b busy=%b valid=%b key_we=%b expected 1 0 0 0",
                     op, sel, err, busy, out_valid, key_we);
        end
        @(negedge clock);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear op=%0d sel=%0d err=%b busy=%b ready=%b expected 0 0 1",
                     op, sel, err, busy, instr_ready);
        end
    endtask

    task automatic test_nop();
        drive_cmd(2'b11, 4'($urandom_range(0, 15)));
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nop err=%b busy=%b ready=%b valid=%b expected 0 0 1 0",
                     err, busy, instr_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        drive_cmd(2'b01, 4'd2);
        for (int k = 0; k < 2; k++) begin
            instr = $urandom;
            instr_valid = 1'b1;
            @(negedge clock);
        end
        instr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (write_bus !== '0 || write_enable !== '0 || instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_write bus_zero=%b we=%h ready=%b busy=%b expected 1 0 1 0",
                     write_bus === '0, write_enable, instr_ready, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (write_enable !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_commit c=%0d we=%h busy=%b expected 0 0", c, write_enable, busy);
            end
        end
    endtask

`ifdef CMD_ABORT_EN
    task automatic test_abort();
        drive_cmd(2'b10, 4'd3);
        repeat (5) @(negedge clock);
        n_checks++;
        if (slice_sel !== 5'd5 || key_we !== 6'b001000) begin
            n_fail++;
            $display("FAIL abort_pre slice=%0d key_we=%b expected 5 001000", slice_sel, key_we);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_checks++;
        if (key_we !== '0 || err !== 1'b1 || busy !== 1'b0 || slice_sel !== '0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_key key_we=%b err=%b busy=%b slice=%0d ready=%b expected 0 1 0 0 1",
                     key_we, err, busy, slice_sel, instr_ready);
        end
        test_read(4, 1'b0);
        drive_cmd(2'b01, 4'd2);
        instr = $urandom;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_checks++;
        if (write_bus !== '0 || write_enable !== '0 || err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write bus_zero=%b we=%h err=%b busy=%b expected 1 0 1 0",
                     write_bus === '0, write_enable, err, busy);
        end
        @(negedge clock);
        n_checks++;
        if (write_enable !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after we=%h err=%b expected 0 0", write_enable, err);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int sel;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    do sel = $urandom_range(0, 15); while (rw_len(sel) == 0);
                    test_read(sel, 1'b0);
                end
                1: begin
                    do sel = $urandom_range(0, 15); while (rw_len(sel) == 0);
                    test_write(sel, 1'b0);
                end
                2: begin
                    do sel = $urandom_range(0, 5); while (key_len(sel) == 0);
                    test_key(sel);
                end
                3: begin
                    case ($urandom_range(0, 2))
                        0: test_error(2'b00, 15);
                        1: test_error(2'b10, 4);
                        default: test_error(2'b10, $urandom_range(6, 15));
                    endcase
                end
                default: test_nop();
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read(4, 1'b1);
        test_write(2, 1'b1);
        test_key(3);
        test_error(2'b00, 15);
        test_error(2'b10, 7);
        test_error(2'b10, 4);
        test_error(2'b01, 15);
        test_nop();
        test_read(5, 1'b0);
        test_write(4, 1'b0);
        test_key(0);
        test_reset_mid_write();
`ifdef CMD_ABORT_EN
        test_abort();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
